// File: rtl/hid_pkg.sv
// Shared types and matrix constants for the CPC keyboard autotype sequencer.
package hid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SHIFT_ON,
    PRESS,
    RELEASE,
    PAUSE
  } autotype_state_t;

  localparam logic [3:0] SHIFT_ROW  = 4'd2;
  localparam logic [2:0] SHIFT_COL  = 3'd5;
  localparam logic [7:0] PAUSE_CODE = 8'hFF;
  localparam int         NUM_ROWS   = 10;

endpackage

// File: rtl/autotype_seq_if.sv
// Command handshake, frame tick, abort and matrix scan signals of the autotype sequencer.
interface autotype_seq_if;
  logic       tick;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       abort;
  logic [3:0] Y;
  logic [7:0] inj_x;
  logic       busy;

  modport master (
    output tick, cmd_valid, cmd_data, abort, Y,
    input  cmd_ready, inj_x, busy
  );

  modport slave (
    input  tick, cmd_valid, cmd_data, abort, Y,
    output cmd_ready, inj_x, busy
  );
endinterface

// File: rtl/autotype_fifo.sv
// Synchronous show-ahead FIFO with flush; an extra count bit separates full from empty.
module autotype_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush returns to empty.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; contents are only read after being written, and the pointers carry validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/autotype_seq.sv
// Autotype sequencer: replays queued matrix codes as timed key presses for the CPC firmware scan.
module autotype_seq #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_TICKS  = 2,
  parameter int GAP_TICKS   = 2,
  parameter int PAUSE_TICKS = 25
) (
  input  logic           clk,
  input  logic           reset_n,
  autotype_seq_if.slave  bus
);
  import hid_pkg::*;

  autotype_state_t state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [3:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic            sft_q, sft_d;
  logic            key_on_q, key_on_d;
  logic            shift_on_q, shift_on_d;

  logic [7:0]      fifo_dout;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;

  // A command handshaked while abort is high is discarded.
  assign fifo_push = bus.cmd_valid && !fifo_full && !bus.abort;

  autotype_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (bus.cmd_data),
    .pop     (fifo_pop),
    .flush   (bus.abort),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State and key registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      sft_q      <= 1'b0;
      key_on_q   <= 1'b0;
      shift_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sft_q      <= sft_d;
      key_on_q   <= key_on_d;
      shift_on_q <= shift_on_d;
    end
  end

  // Next-state: command decode, tick-timed phases, abort override.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bus.tick ? cnt_q + 16'd1 : cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    sft_d      = sft_q;
    key_on_d   = key_on_q;
    shift_on_d = shift_on_q;
    fifo_pop   = 1'b0;

    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        row_d    = fifo_dout[3:0];
        col_d    = fifo_dout[6:4];
        sft_d    = fifo_dout[7];
        state_d  = DECODE;
      end
      DECODE: begin
        if ({sft_q, col_q, row_q} == PAUSE_CODE) begin
          state_d = PAUSE;
        end else if (row_q >= 4'(NUM_ROWS)) begin
          state_d = IDLE;
        end else if (sft_q) begin
          state_d    = SHIFT_ON;
          shift_on_d = 1'b1;
        end else begin
          state_d  = PRESS;
          key_on_d = 1'b1;
        end
      end
      SHIFT_ON: if (bus.tick && cnt_q == 16'd0) begin
        state_d  = PRESS;
        key_on_d = 1'b1;
      end
      PRESS: if (bus.tick && cnt_q == 16'(HOLD_TICKS - 1)) begin
        state_d    = RELEASE;
        key_on_d   = 1'b0;
        shift_on_d = 1'b0;
      end
      RELEASE: if (bus.tick && cnt_q == 16'(GAP_TICKS - 1)) state_d = IDLE;
      PAUSE:   if (bus.tick && cnt_q == 16'(PAUSE_TICKS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    if (bus.abort) begin
      state_d    = IDLE;
      cnt_d      = '0;
      key_on_d   = 1'b0;
      shift_on_d = 1'b0;
      fifo_pop   = 1'b0;
    end
  end

  // Outputs: pressed mask for the scanned row, handshake ready, activity flag.
  always_comb begin
    bus.inj_x = '0;
    if (key_on_q && bus.Y == row_q)       bus.inj_x[col_q]     = 1'b1;
    if (shift_on_q && bus.Y == SHIFT_ROW) bus.inj_x[SHIFT_COL] = 1'b1;
    bus.cmd_ready = !fifo_full;
    bus.busy      = (state_q != IDLE) || !fifo_empty;
  end

endmodule

// File: tb/tb_autotype_seq.sv
// Self-checking bench for autotype_seq: table-driven key sequences plus directed corner cases.
`timescale 1ns/1ps
module tb_autotype_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #50 clk = ~clk;

  autotype_seq_if bus ();

  autotype_seq #(
    .FIFO_DEPTH(8), .HOLD_TICKS(2), .GAP_TICKS(2), .PAUSE_TICKS(25)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] cmd;
    logic       first;
    logic       last;
    logic [7:0] e2;
    logic [7:0] e8;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
  endtask

  task automatic push(input logic [7:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  // Scans rows 0..9: rows 2 and 8 checked exactly, all others must be empty.
  task automatic check_rows(input string nm, input logic [7:0] e2, input logic [7:0] e8);
    logic [7:0] others = '0;
    logic [7:0] got2 = '0;
    logic [7:0] got8 = '0;
    for (int y = 0; y < 10; y++) begin
      bus.Y = 4'(y);
      #1;
      if (y == 2)      got2 = bus.inj_x;
      else if (y == 8) got8 = bus.inj_x;
      else             others = others | bus.inj_x;
    end
    check({nm, "_y2"}, 32'(got2), 32'(e2));
    check({nm, "_y8"}, 32'(got8), 32'(e8));
    check({nm, "_other"}, 32'(others), 32'h0);
  endtask

  initial begin
    int acc;
    logic [11:0] rdy_seq;
    logic saw_early;

    //           cmd     first last  Y=2    Y=8
    vecs[0]  = '{8'h38, 1'b1, 1'b0, 8'h00, 8'h08};
    vecs[1]  = '{8'h38, 1'b0, 1'b0, 8'h00, 8'h08};
    vecs[2]  = '{8'h38, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{8'h38, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[4]  = '{8'hB8, 1'b1, 1'b0, 8'h20, 8'h00};
    vecs[5]  = '{8'hB8, 1'b0, 1'b0, 8'h20, 8'h08};
    vecs[6]  = '{8'hB8, 1'b0, 1'b0, 8'h20, 8'h08};
    vecs[7]  = '{8'hB8, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{8'hB8, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[9]  = '{8'h72, 1'b1, 1'b0, 8'h80, 8'h00};
    vecs[10] = '{8'h72, 1'b0, 1'b0, 8'h80, 8'h00};
    vecs[11] = '{8'h72, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[12] = '{8'h72, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[13] = '{8'hA2, 1'b1, 1'b0, 8'h20, 8'h00};
    vecs[14] = '{8'hA2, 1'b0, 1'b0, 8'h24, 8'h00};
    vecs[15] = '{8'hA2, 1'b0, 1'b0, 8'h24, 8'h00};
    vecs[16] = '{8'hA2, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[17] = '{8'hA2, 1'b0, 1'b1, 8'h00, 8'h00};

    bus.tick      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.abort     = 1'b0;
    bus.Y         = '0;

    // Reset state.
    #120 reset_n = 1'b1;
    #10;
    check("reset_ready", 32'(bus.cmd_ready), 32'h1);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check_rows("reset_inj", 8'h00, 8'h00);
    step(1);

    // Table-driven key sequences: push, two clocks through IDLE/DECODE, then one row of checks per tick.
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].first) begin
        push(vecs[i].cmd);
        step(2);
      end
      check_rows($sformatf("vec%0d", i), vecs[i].e2, vecs[i].e8);
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'h1);
      pulse_tick();
      if (vecs[i].last) check($sformatf("vec%0d_done", i), 32'(bus.busy), 32'h0);
    end

    // FIFO full: offer commands for 12 clocks with no ticks; the first pop frees one slot.
    acc = 0;
    rdy_seq = '0;
    for (int i = 0; i < 12; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'h38;
      rdy_seq[i] = bus.cmd_ready;
      if (bus.cmd_ready) acc++;
      step(1);
    end
    bus.cmd_valid = 1'b0;
    check("full_accepts", 32'(acc), 32'd9);
    check("full_ready_seq", 32'(rdy_seq), 32'h1FF);
    check("full_ready_end", 32'(bus.cmd_ready), 32'h0);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check("full_flush_busy", 32'(bus.busy), 32'h0);
    check("full_flush_ready", 32'(bus.cmd_ready), 32'h1);
    check_rows("full_flush_inj", 8'h00, 8'h00);

    // Pause then Q: nothing injected for 25 ticks, then Q pressed.
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'hFF;
    step(1);
    bus.cmd_data  = 8'h38;
    step(1);
    bus.cmd_valid = 1'b0;
    step(1);
    saw_early = 1'b0;
    bus.Y = 4'd8;
    for (int t = 0; t < 25; t++) begin
      #1;
      if (bus.inj_x != 8'h00) saw_early = 1'b1;
      pulse_tick();
    end
    check("pause_quiet", 32'(saw_early), 32'h0);
    check("pause_busy", 32'(bus.busy), 32'h1);
    step(2);
    check_rows("pause_then_q", 8'h00, 8'h08);
    repeat (4) pulse_tick();
    check("pause_q_done", 32'(bus.busy), 32'h0);

    // Row 15 is dropped without needing a tick.
    push(8'h0F);
    check("row15_busy", 32'(bus.busy), 32'h1);
    step(2);
    check("row15_dropped", 32'(bus.busy), 32'h0);
    check_rows("row15_inj", 8'h00, 8'h00);

    // Abort mid-PRESS together with tick and a new command.
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 8'h38; step(1);
    bus.cmd_data = 8'h48; step(1);
    bus.cmd_data = 8'h58; step(1);
    bus.cmd_data = 8'h68; step(1);
    bus.cmd_valid = 1'b0;
    pulse_tick();
    check_rows("abort_pre", 8'h00, 8'h08);
    bus.abort     = 1'b1;
    bus.tick      = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h55;
    step(1);
    bus.abort     = 1'b0;
    bus.tick      = 1'b0;
    bus.cmd_valid = 1'b0;
    check_rows("abort_inj", 8'h00, 8'h00);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_ready", 32'(bus.cmd_ready), 32'h1);
    step(2);
    pulse_tick();
    check("abort_no_exec", 32'(bus.busy), 32'h0);

    // Async reset in SHIFT_ON with no clock edge.
    push(8'hB8);
    step(2);
    check_rows("rst_pre", 8'h20, 8'h00);
    bus.Y = 4'd2;
    #10 reset_n = 1'b0;
    #1;
    check("rst_inj_now", 32'(bus.inj_x), 32'h0);
    #10 reset_n = 1'b1;
    #1;
    check("rst_ready", 32'(bus.cmd_ready), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    step(2);
    check("rst_busy_later", 32'(bus.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
